// File: rtl/prca_pkg.sv
// ============================================================================
//  Module   : prca_pkg
//  Purpose  : Shared types and helpers for the pipelined ripple-carry adder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package prca_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of pipeline stages; a degenerate SEG still yields one stage so
    // the elaboration check in the top can report the bad configuration.
    function automatic int calc_stages(input int width, input int seg);
        return (seg > 0) ? (width / seg) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rca_seg.sv
// ============================================================================
//  Module   : rca_seg
//  Purpose  : Combinational SEG-bit ripple adder built from full-adder cells;
//             also exposes the carry into the MSB for signed-overflow use.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rca_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG:0] w_c;

    // One full-adder cell per bit, carry rippling upward.
    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = w_c[SEG];
    assign c_msb = w_c[SEG-1];

endmodule

`default_nettype wire

// File: rtl/pipe_rca.sv
// ============================================================================
//  Module   : pipe_rca
//  Purpose  : Pipelined ripple-carry add/subtract, SEG bits resolved per stage,
//             valid/ready on both sides. Define PRCA_OVF_EN for the ovf port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_rca
    import prca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef PRCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int STAGES = calc_stages(WIDTH, SEG);

    if ((SEG < 1) || ((WIDTH % SEG) != 0)) begin : g_cfg_err
        $error("pipe_rca: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
    end

    // Full-width a/b' travel with each record; stage k consumes segment k of
    // them and deposits segment k of the sum.
    typedef struct packed {
        logic             valid;
        op_e              op;
        logic             carry;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t           r_stg   [STAGES];
    stage_t           w_src   [STAGES];
    stage_t           w_nxt   [STAGES];
    logic [SEG-1:0]   w_seg_s [STAGES];
    logic [STAGES-1:0] w_co;
    logic [STAGES-1:0] w_cmsb;
    stage_t           w_in;
    logic             w_stall;
    logic             w_unused;

    function automatic stage_t next_rec(input stage_t src, input logic [SEG-1:0] seg_s,
                                        input logic seg_co, input int idx);
        stage_t r;
        r                      = src;
        r.sum[idx*SEG +: SEG]  = seg_s;
        r.carry                = seg_co;
        return r;
    endfunction

    assign w_stall   = r_stg[STAGES-1].valid & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_stg[STAGES-1].valid;
    assign s         = r_stg[STAGES-1].sum;
    assign co        = r_stg[STAGES-1].carry;

    // Subtraction is a + ~b + 1; ci only matters in add mode.
    always_comb begin
        w_in       = '0;
        w_in.valid = in_valid;
        w_in.op    = sub ? OP_SUB : OP_ADD;
        w_in.carry = sub ? 1'b1 : ci;
        w_in.a     = a;
        w_in.b     = sub ? ~b : b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_src[k] = w_in;
        end else begin : g_chain
            assign w_src[k] = r_stg[k-1];
        end

        rca_seg #(
            .SEG (SEG)
        ) u_seg (
            .a     (w_src[k].a[k*SEG +: SEG]),
            .b     (w_src[k].b[k*SEG +: SEG]),
            .ci    (w_src[k].carry),
            .s     (w_seg_s[k]),
            .co    (w_co[k]),
            .c_msb (w_cmsb[k])
        );

        assign w_nxt[k] = next_rec(w_src[k], w_seg_s[k], w_co[k], k);
    end

    // A stall freezes every stage; bubbles are not collapsed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stg[k] <= '0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stg[k] <= w_nxt[k];
            end
        end
    end

`ifdef PRCA_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (!w_stall) begin
            r_ovf <= w_cmsb[STAGES-1] ^ w_co[STAGES-1];
        end
    end

    assign ovf = r_ovf;
`endif

    // Operand bits already consumed by the last stage and intermediate MSB
    // carries have no consumer.
    assign w_unused = ^{w_cmsb, r_stg[STAGES-1].op, r_stg[STAGES-1].a, r_stg[STAGES-1].b};

endmodule

`default_nettype wire
